digitron_scan_display: RTL

- Parametrised, time-multiplexed driver for a common-cathode 7-segment bank of `DIGITS` digits.
- Latches a packed hex value plus decimal-point mask on a `load` strobe and scans one digit per `SCAN_DIV` clocks.
- Commits new data only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the counter/timer logic and the board's segment and digit-select pins; replaces the single-digit driver.

---
 rtl/digitron_scan_display.sv | 134 +++++++++++++
 1 files changed

// File: rtl/digitron_scan_display.sv
// Time-multiplexed common-cathode 7-segment driver for DIGITS digits; data committed only at frame boundaries.
// Latency: load to visible within DIGITS*SCAN_DIV clocks (1 clock when load hits the boundary cycle).
// Backpressure: none; load is a strobe and last load before a boundary wins. Optional: DIGITRON_BLANK_LZ_EN.
module digitron_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  output logic [7:0]            Digitron_Out,
  output logic [DIGITS-1:0]     DigitronCS_Out,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pdata;
  logic [DIGITS-1:0]   pdp;
  logic                pend;
  logic [4*DIGITS-1:0] ddata;
  logic [DIGITS-1:0]   ddp;

  logic                tc;
  logic                boundary;
  logic [IW-1:0]       idx_nxt;
  logic [4*DIGITS-1:0] ddata_nxt;
  logic [DIGITS-1:0]   ddp_nxt;
  logic [3:0]          nib;
  logic                blank;
  logic [6:0]          seg7;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      4'hF: seg_decode = 7'h71;
    endcase
  endfunction

  // Scan control and the display contents/segments that become visible on the next terminal count.
  // Segments are decoded from the post-commit display value so select and segments change together.
  always_comb begin
    tc        = (cnt == CNT_MAX);
    boundary  = tc && (idx == IDX_MAX);
    idx_nxt   = (idx == IDX_MAX) ? '0 : idx + IW'(1);
    ddata_nxt = ddata;
    ddp_nxt   = ddp;
    if (boundary) begin
      if (load) begin
        ddata_nxt = data;
        ddp_nxt   = dp;
      end else if (pend) begin
        ddata_nxt = pdata;
        ddp_nxt   = pdp;
      end
    end
    nib = ddata_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef DIGITRON_BLANK_LZ_EN
    // A digit above 0 goes dark when it and every more-significant digit are zero.
    blank = (idx_nxt != '0) && ((ddata_nxt >> {idx_nxt, 2'b00}) == '0);
`else
    blank = 1'b0;
`endif
    seg7 = blank ? 7'h00 : seg_decode(nib);
  end

  // Prescaler and digit index; idx starts at the last digit so the first terminal count is a frame boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= IDX_MAX;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc) idx <= idx_nxt;
    end
  end

  // Pending and display storage; a boundary always consumes the pending slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pdata <= '0;
      pdp   <= '0;
      pend  <= 1'b0;
      ddata <= '0;
      ddp   <= '0;
    end else begin
      if (load) begin
        pdata <= data;
        pdp   <= dp;
      end
      if (boundary)  pend <= 1'b0;
      else if (load) pend <= 1'b1;
      ddata <= ddata_nxt;
      ddp   <= ddp_nxt;
    end
  end

  // Registered pin drivers; segments and select update only on the terminal-count edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Digitron_Out   <= 8'h00;
      DigitronCS_Out <= '1;
      frame_tick     <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (tc) begin
        Digitron_Out   <= {ddp_nxt[idx_nxt], seg7};
        DigitronCS_Out <= ~(DIGITS'(1) << idx_nxt);
      end
    end
  end

endmodule
